l2_arbiter: RTL and testbench



---
 rtl/l2_arbiter_pkg.sv | 41 ++++
 rtl/l2_arbiter_req_reg.sv | 35 +++
 rtl/l2_arbiter.sv | 122 ++++++++++++
 tb/tb_l2_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 request arbiter: line/word types, FSM states,
// port and operation encodings, and the registered-request record.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } l2_arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } l2_arb_port_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } l2_arb_op_t;

  // One granted request as presented to the L2 cache.
  typedef struct packed {
    lc3b_word     address;
    lc3b_line     wdata;
    l2_arb_op_t   op;
    l2_arb_port_t port;
  } l2_arb_req_t;

  localparam l2_arb_req_t L2_ARB_REQ_RESET = '{
    address: '0,
    wdata:   '0,
    op:      OP_READ,
    port:    PORT_I
  };

endpackage

// File: rtl/l2_arbiter_req_reg.sv
// Request register for the L2 arbiter: captures the winning request on the
// grant strobe and holds it for the whole L2 transaction, so requester input
// changes after the grant never reach the l2_* outputs.
module l2_arb_req_reg
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  l2_arb_req_t load_req,
  output l2_arb_req_t req
);

  l2_arb_req_t req_d;
  l2_arb_req_t req_q;

  // Load a new request on grant, otherwise hold.
  always_comb begin
    req_d = load ? load_req : req_q;
  end

  // Request register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its inputs, independent of block ordering.
    if (reset) begin
      req_q <= L2_ARB_REQ_RESET;
    end else begin
      req_q <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/l2_arbiter.sv
// Two-port (icache/dcache) arbiter in front of the L2 cache. One request is
// granted at a time, registered, and presented on the l2_* port; the L2 line
// is captured and returned to the requester one cycle after l2_resp.
// Build option: L2_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it the dcache always wins a tie.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_mem_read,
  input  lc3b_word i_mem_address,
  output lc3b_line i_mem_rdata,
  output logic     i_mem_resp,
  input  logic     d_mem_read,
  input  logic     d_mem_write,
  input  lc3b_word d_mem_address,
  input  lc3b_line d_mem_wdata,
  output lc3b_line d_mem_rdata,
  output logic     d_mem_resp,
  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_line l2_wdata,
  input  lc3b_line l2_rdata,
  input  logic     l2_resp
);

  l2_arb_state_t state_q, state_d;
  l2_arb_port_t  last_grant_q, last_grant_d;
  lc3b_line      resp_data_q, resp_data_d;

  logic          i_req, d_req, grant;
  l2_arb_port_t  grant_port;
  l2_arb_req_t   new_req, req;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;
  assign grant = (state_q == IDLE) && (i_req || d_req);

  // Choose the winning port and build the request to register.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_port = PORT_D;
    if (i_req && d_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      grant_port = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
`else
      grant_port = PORT_D;
`endif
    end else if (i_req) begin
      grant_port = PORT_I;
    end
    new_req.port    = grant_port;
    new_req.address = (grant_port == PORT_I) ? i_mem_address : d_mem_address;
    new_req.wdata   = (grant_port == PORT_D) ? d_mem_wdata : '0;
    // A simultaneous dcache read and write is a write.
    new_req.op      = ((grant_port == PORT_D) && d_mem_write) ? OP_WRITE : OP_READ;
  end

  l2_arb_req_reg u_req_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_req (new_req),
    .req      (req)
  );

  // State, last-grant and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state logic; l2_resp is only honoured while serving.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = (grant_port == PORT_I) ? SERVE_I : SERVE_D;
          last_grant_d = grant_port;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          resp_data_d = l2_rdata;
          state_d     = (req.port == PORT_I) ? RESP_I : RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the request/response registers only.
  always_comb begin
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    if ((state_q == SERVE_I) || (state_q == SERVE_D)) begin
      l2_read  = (req.op == OP_READ);
      l2_write = (req.op == OP_WRITE);
    end
    l2_address  = req.address;
    l2_wdata    = req.wdata;
    i_mem_resp  = (state_q == RESP_I);
    d_mem_resp  = (state_q == RESP_D);
    i_mem_rdata = resp_data_q;
    d_mem_rdata = resp_data_q;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter. A transaction-level model decides the
// grant order from the arbitration rule and a remembered last grant; a small
// L2 responder with random latency and data drives the l2_* inputs.
module tb_l2_arbiter;

  logic         clk;
  logic         reset;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic [127:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  typedef enum bit {P_I = 1'b0, P_D = 1'b1} port_t;

  int    vectors = 0;
  int    miscompares = 0;
  port_t last_m;

  l2_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_resp    (i_mem_resp),
    .d_mem_read    (d_mem_read),
    .d_mem_write   (d_mem_write),
    .d_mem_address (d_mem_address),
    .d_mem_wdata   (d_mem_wdata),
    .d_mem_rdata   (d_mem_rdata),
    .d_mem_resp    (d_mem_resp),
    .l2_read       (l2_read),
    .l2_write      (l2_write),
    .l2_address    (l2_address),
    .l2_wdata      (l2_wdata),
    .l2_rdata      (l2_rdata),
    .l2_resp       (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic port_t tie_winner(input port_t last);
`ifdef L2_ARB_ROUND_ROBIN_EN
    return (last == P_D) ? P_I : P_D;
`else
    return P_D;
`endif
  endfunction

  task automatic apply_reset();
    i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    i_mem_address = '0; d_mem_address = '0; d_mem_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_m = P_D;
  endtask

  // Wait for the L2 request of port p, check it, answer after lat extra
  // cycles with rd, then check the one-cycle response pulse and data.
  task automatic serve_one(input port_t p, input bit wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int lat,
                           input logic [127:0] rd, input bit scramble);
    int waited = 0;
    bit seen = 1'b0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = l2_read | l2_write;
    end
    vectors++;
    if (!seen || waited != 1) begin
      miscompares++;
      $display("FAIL grant_latency port=%0d: waited %0d cycles (seen=%0b), expected 1", p, waited, seen);
    end
    if (!seen) return;
    vectors++;
    if ({l2_read, l2_write} !== {~wr, wr}) begin
      miscompares++;
      $display("FAIL l2_op port=%0d: read/write=%b, expected %b", p, {l2_read, l2_write}, {~wr, wr});
    end
    vectors++;
    if (l2_address !== addr) begin
      miscompares++;
      $display("FAIL l2_address port=%0d: got %h, expected %h", p, l2_address, addr);
    end
    if (wr) begin
      vectors++;
      if (l2_wdata !== wd) begin
        miscompares++;
        $display("FAIL l2_wdata: got %h, expected %h", l2_wdata, wd);
      end
    end
    for (int c = 0; c < lat; c++) begin
      if (scramble) begin
        if (p == P_I) i_mem_address = ~addr;
        else          d_mem_address = ~addr;
      end
      @(negedge clk);
      vectors++;
      if (l2_address !== addr || {l2_read, l2_write} !== {~wr, wr}) begin
        miscompares++;
        $display("FAIL l2_hold port=%0d: addr %h rw %b, expected addr %h rw %b",
                 p, l2_address, {l2_read, l2_write}, addr, {~wr, wr});
      end
    end
    l2_resp  = 1'b1;
    l2_rdata = rd;
    @(negedge clk);
    l2_resp  = 1'b0;
    l2_rdata = rand_line();
    vectors++;
    if ({i_mem_resp, d_mem_resp} !== ((p == P_I) ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL resp_pulse port=%0d: i/d resp=%b", p, {i_mem_resp, d_mem_resp});
    end
    vectors++;
    if (((p == P_I) ? i_mem_rdata : d_mem_rdata) !== rd) begin
      miscompares++;
      $display("FAIL resp_rdata port=%0d: got %h, expected %h", p,
               (p == P_I) ? i_mem_rdata : d_mem_rdata, rd);
    end
    if (p == P_I) begin
      i_mem_read = 1'b0; i_mem_address = addr;
    end else begin
      d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = addr;
    end
    @(negedge clk);
    vectors++;
    if ({i_mem_resp, d_mem_resp, l2_read, l2_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL back_to_idle port=%0d: i/d resp, l2 r/w = %b, expected 0000",
               p, {i_mem_resp, d_mem_resp, l2_read, l2_write});
    end
  endtask

  // Present requests at an IDLE negedge and serve them in model order.
  task automatic do_round(input bit ir, input bit drd, input bit dwr,
                          input logic [15:0] ia, input logic [15:0] da,
                          input logic [127:0] wd, input int lat_i, input int lat_d,
                          input logic [127:0] rdi, input logic [127:0] rdd,
                          input bit scramble);
    bit    dreq;
    port_t first;
    i_mem_read = ir; i_mem_address = ia;
    d_mem_read = drd; d_mem_write = dwr; d_mem_address = da; d_mem_wdata = wd;
    dreq = drd | dwr;
    if (!ir && !dreq) begin
      @(negedge clk);
      vectors++;
      if ({l2_read, l2_write, i_mem_resp, d_mem_resp} !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_no_req: l2 r/w, i/d resp = %b, expected 0000",
                 {l2_read, l2_write, i_mem_resp, d_mem_resp});
      end
      return;
    end
    if (ir && dreq) first = tie_winner(last_m);
    else            first = ir ? P_I : P_D;
    if (first == P_I) serve_one(P_I, 1'b0, ia, wd, lat_i, rdi, scramble);
    else              serve_one(P_D, dwr, da, wd, lat_d, rdd, scramble);
    last_m = first;
    if (ir && dreq) begin
      if (first == P_I) begin
        serve_one(P_D, dwr, da, wd, lat_d, rdd, scramble);
        last_m = P_D;
      end else begin
        serve_one(P_I, 1'b0, ia, wd, lat_i, rdi, scramble);
        last_m = P_I;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp, l2_read, l2_write,
         l2_address, l2_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: l2 r/w=%b addr=%h resp=%b, expected all zero",
               {l2_read, l2_write}, l2_address, {i_mem_resp, d_mem_resp});
    end
  endtask

  task automatic test_icache_read();
    do_round(1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, '0, 2, 0,
             {16{8'hA5}}, '0, 1'b0);
  endtask

  task automatic test_dcache_write();
    do_round(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4560,
             {4{32'h0123_4567, 32'h89AB_CDEF}} >> 0, 0, 1, '0, rand_line(), 1'b0);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    do_round(1'b1, 1'b1, 1'b0, 16'h1000, 16'h2000, rand_line(), 1, 2,
             rand_line(), rand_line(), 1'b0);
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++)
      do_round(1'b1, 1'b1, r[0], 16'h3000 + 16'(r), 16'h5000 + 16'(r), rand_line(),
               0, 1, rand_line(), rand_line(), 1'b0);
  endtask

  task automatic test_addr_change();
    do_round(1'b1, 1'b1, 1'b1, 16'h0ABC, 16'h0DEF, rand_line(), 2, 2,
             rand_line(), rand_line(), 1'b1);
  endtask

  task automatic test_stray_resp();
    l2_resp = 1'b1; l2_rdata = rand_line();
    @(negedge clk);
    l2_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({i_mem_resp, d_mem_resp, l2_read, l2_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL stray_resp: i/d resp, l2 r/w = %b, expected 0000",
                 {i_mem_resp, d_mem_resp, l2_read, l2_write});
      end
    end
  endtask

  task automatic test_reset_mid_txn();
    int  waited = 0;
    d_mem_write = 1'b1; d_mem_address = 16'h7770; d_mem_wdata = rand_line();
    while (!l2_write && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!l2_write) begin
      miscompares++;
      $display("FAIL reset_mid_grant: l2_write=%b after %0d cycles, expected 1", l2_write, waited);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp, l2_read, l2_write,
         l2_address, l2_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: l2 r/w=%b addr=%h resp=%b, expected all zero",
               {l2_read, l2_write}, l2_address, {i_mem_resp, d_mem_resp});
    end
    reset = 1'b0;
    d_mem_write = 1'b0;
    last_m = P_D;
    do_round(1'b1, 1'b0, 1'b0, 16'h1357, 16'h0000, '0, 1, 0,
             rand_line(), '0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      do_round(sel[0], sel[1], sel[2], 16'($urandom()), 16'($urandom()), rand_line(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               rand_line(), rand_line(), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_simultaneous();
    test_contention();
    test_addr_change();
    test_stray_resp();
    test_reset_mid_txn();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
